// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding fetch stage with PC redirect; FETCH_ALIGN_CHECK_EN adds sticky addr_err on misaligned JR
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        addr_err,
`endif
  input  logic        halt
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALTED} state_t;
  state_t      state_q;
  logic [31:0] pc_q, pc_d, instr_q, br_off;
  logic        imem_req_q, instr_valid_q, halt_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        addr_err_q, misaligned;
  assign addr_err = addr_err_q;
`endif
  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    pc_d     = jump_reg ? (jr_target & ~32'd3) :
               jump ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
               (branch & branch_taken) ? pc_plus4 + br_off : pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned = jump_reg & (|jr_target[1:0]);
    halt_d     = halt | misaligned;
`else
    halt_d     = halt;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_WORD;
`ifdef FETCH_ALIGN_CHECK_EN
      addr_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          imem_req_q <= 1'b1;
          state_q    <= S_WAIT;
        end
        S_WAIT: if (imem_ack) begin
          instr_q       <= imem_rdata;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b1;
          state_q       <= S_HOLD;
        end
        S_HOLD: if (instr_valid_q & instr_ready) begin
          instr_valid_q <= 1'b0;
          instr_q       <= NOP_WORD;
          pc_q          <= pc_d;
          state_q       <= halt_d ? S_HALTED : S_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
          addr_err_q    <= addr_err_q | misaligned;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
